// File: rtl/phase5_writeback.sv
// Writeback stage and architectural register file with per-register busy scoreboard.
// Latency: register write lands 1 clock after presentation; reads, bypass and stall are combinational.
// Backpressure: none accepted from writeback; decode is held via stall while a source register is busy.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   MemtoReg/RegWrite/RegDst   writeback control: source select, enable, destination
//   mem_rdata/alu_result       candidate writeback values
//   ra_addr/rb_addr            decode read addresses; ra_use/rb_use mark them as needed
//   busy_set/busy_set_addr     decode issued a producer for that register
//   ra_data/rb_data            bypassed read data
//   stall                      decode must hold this cycle
//   wb_valid_q/wb_data_q       registered record of last cycle's write
module phase5_writeback #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [AW-1:0]     RegDst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  input  logic              ra_use,
  input  logic              rb_use,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_set_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              stall,
  output logic              wb_valid_q,
  output logic [DATA_W-1:0] wb_data_q
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   setVec;
  logic [NREG-1:0]   clrVec;
  logic [DATA_W-1:0] wbData;
  logic              hitA;
  logic              hitB;

  assign wbData = MemtoReg ? mem_rdata : alu_result;

  // A write being presented this cycle is forwarded straight to decode.
  assign hitA = RegWrite && (RegDst == ra_addr);
  assign hitB = RegWrite && (RegDst == rb_addr);

  assign ra_data = hitA ? wbData : regs[ra_addr];
  assign rb_data = hitB ? wbData : regs[rb_addr];

  // A busy source whose producer is writing back right now is served by the bypass.
  assign stall = (ra_use && busy[ra_addr] && !hitA) ||
                 (rb_use && busy[rb_addr] && !hitB);

  always_comb begin
    setVec = '0;
    clrVec = '0;
    for (int i = 0; i < NREG; i++) begin
      setVec[i] = busy_set && (busy_set_addr == AW'(i));
      clrVec[i] = RegWrite && (RegDst == AW'(i));
    end
  end

  // Set has priority over clear: an issue in the same cycle as a writeback
  // to that register means a newer producer is now in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= setVec | (busy & ~clrVec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite) begin
      regs[RegDst] <= wbData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= RegWrite;
      if (RegWrite) begin
        wb_data_q <= wbData;
      end
    end
  end

endmodule
